// File: rtl/line_window_3x3.sv
// Sliding 3x3 window over a column-padded pixel stream, with zero rows supplied
// above the first and below the last image row so every pixel gets a centred window.
module line_window_3x3 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LINE_LEN   = 640,
  parameter int unsigned ROWS       = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [9*DATA_WIDTH-1:0] win_out,
  output logic                    win_valid,
  output logic [15:0]             out_row,
  output logic [15:0]             out_col,
  output logic                    frame_done
);

  localparam int unsigned ColW = $clog2(LINE_LEN);
  localparam int unsigned RowW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {StIdle, StFill, StRun, StFlush, StDone} state_e;

  state_e                state_q;
  logic [ColW-1:0]       in_col_q;
  logic [RowW-1:0]       in_row_q;
  logic [DATA_WIDTH-1:0] line_mid [LINE_LEN];
  logic [DATA_WIDTH-1:0] line_top [LINE_LEN];

  logic                    step;
  logic                    col_last;
  logic                    emit;
  logic [DATA_WIDTH-1:0]   px;
  logic [DATA_WIDTH-1:0]   col_tap [3];
  logic [9*DATA_WIDTH-1:0] win_d;

  assign pix_ready = (state_q == StFill) || (state_q == StRun);
  // FLUSH injects a zero pixel every cycle; a frame_start cycle never moves data.
  assign step      = !frame_start && ((pix_valid && pix_ready) || (state_q == StFlush));
  assign col_last  = (in_col_q == ColW'(LINE_LEN - 1));
  assign emit      = step && (in_col_q >= ColW'(2)) &&
                     ((state_q == StRun) || (state_q == StFlush));
  assign px        = (state_q == StFlush) ? '0 : pix_in;

  always_comb begin
    col_tap[0] = (in_row_q == RowW'(1)) ? '0 : line_top[in_col_q];
    col_tap[1] = line_mid[in_col_q];
    col_tap[2] = px;
    win_d      = '0;
    for (int r = 0; r < 3; r++) begin
      win_d[DATA_WIDTH*(3*r)   +: DATA_WIDTH] = win_out[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
      win_d[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = win_out[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
      win_d[DATA_WIDTH*(3*r+2) +: DATA_WIDTH] = col_tap[r];
    end
  end

  // Read-before-write: the old middle-row value migrates into the top-row memory.
  always_ff @(posedge clk) begin
    if (step) begin
      line_mid[in_col_q] <= px;
      line_top[in_col_q] <= col_tap[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      in_col_q   <= '0;
      in_row_q   <= '0;
      win_out    <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      state_q    <= StFill;
      in_col_q   <= '0;
      in_row_q   <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= (state_q == StDone);
      if (emit) begin
        out_col <= 16'(in_col_q) - 16'd2;
        out_row <= 16'(in_row_q) - 16'd1;
      end
      if (step) begin
        win_out <= win_d;
        if (col_last) begin
          in_col_q <= '0;
          in_row_q <= in_row_q + RowW'(1);
        end else begin
          in_col_q <= in_col_q + ColW'(1);
        end
      end
      case (state_q)
        StIdle:  state_q <= StIdle;
        StFill:  if (step && col_last) state_q <= StRun;
        StRun:   if (step && col_last && (in_row_q == RowW'(ROWS - 1))) state_q <= StFlush;
        StFlush: if (col_last) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
